// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
// Register map addresses and controller FSM states.
package irq_pkg;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_MODE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_LOST    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUED,
    GAP
  } state_t;

endpackage

// File: rtl/irq_sync.sv
// One interrupt channel: synchroniser chain, previous-value flop and
// edge/level capture strobe feeding the PENDING register.
module irq_sync
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic mode,
  output logic capture
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s;
  logic                   p;

  assign s = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      p     <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
      p     <= s;
    end
  end

  // level mode re-captures every cycle the source is high
  assign capture = mode ? s : (s & ~p);

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller with per-channel capture and masking.
// Optional LOST register enabled by defining IRQ_LOST_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_raw,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_IRQ-1:0] cfg_d,
  input  logic               cfg_we,
  output logic [NUM_IRQ-1:0] cfg_q,
  output logic               cpu_int,
  output logic [ID_W-1:0]    cpu_int_id,
  input  logic               cpu_ack
);

  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] lost;
  logic [NUM_IRQ-1:0] cap;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] w1c_pend;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] pend_next;
  logic [ID_W-1:0]    win;
  logic               ack_ok;
  state_t             state;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
    irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .raw     (irq_raw[i]),
      .mode    (mode[i]),
      .capture (cap[i])
    );
  end

  assign req    = pending & enable;
  assign ack_ok = (state == ISSUED) && cpu_ack;

  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) win = ID_W'(i);
    end
  end

  always_comb begin
    w1c_pend = '0;
    if (cfg_we && cfg_addr == REG_PENDING) w1c_pend = cfg_d;
  end

  always_comb begin
    ack_clr = '0;
    if (ack_ok) ack_clr = NUM_IRQ'(1) << cpu_int_id;
  end

  // capture beats clear; in level mode this also blocks clear while high
  assign pend_next = cap | (pending & ~(w1c_pend | ack_clr));

  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= '0;
      mode    <= '0;
      pending <= '0;
    end else begin
      pending <= pend_next;
      if (cfg_we && cfg_addr == REG_ENABLE) enable <= cfg_d;
      if (cfg_we && cfg_addr == REG_MODE)   mode   <= cfg_d;
    end
  end

`ifdef IRQ_LOST_EN
  logic [NUM_IRQ-1:0] w1c_lost;
  logic [NUM_IRQ-1:0] overrun;

  always_comb begin
    w1c_lost = '0;
    if (cfg_we && cfg_addr == REG_LOST) w1c_lost = cfg_d;
  end

  assign overrun = cap & ~mode & pending;

  always_ff @(posedge clk) begin
    if (reset) lost <= '0;
    else       lost <= overrun | (lost & ~w1c_lost);
  end
`else
  assign lost = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q <= '0;
    end else begin
      unique case (cfg_addr)
        REG_ENABLE:  cfg_q <= enable;
        REG_MODE:    cfg_q <= mode;
        REG_PENDING: cfg_q <= pending;
        REG_LOST:    cfg_q <= lost;
        default:     cfg_q <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_int    <= 1'b0;
      cpu_int_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            cpu_int_id <= win;
            cpu_int    <= 1'b1;
            state      <= ISSUED;
          end
        end
        ISSUED: begin
          if (cpu_ack) begin
            cpu_int <= 1'b0;
            state   <= GAP;
          end
        end
        GAP: begin
          cpu_int <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          cpu_int <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
